// File: rtl/ofs_feature_csr_pkg.sv
// ofs_feature_csr_pkg: shared offsets, FSM states and completion record for the feature CSR responder
package ofs_feature_csr_pkg;
  localparam int unsigned DFH_OFFSET    = 'h0;
  localparam int unsigned GUID_L_OFFSET = 'h8;
  localparam int unsigned GUID_H_OFFSET = 'h10;
  localparam int unsigned CSR_TAG_MAX   = 16;
  typedef enum logic {IDLE, RSP} t_csr_state;
  typedef struct packed {
    logic [63:0]            data;
    logic [CSR_TAG_MAX-1:0] tag;
    logic                   err;
  } t_csr_rsp;
endpackage

// File: rtl/feature_csr_sat_cnt.sv
// feature_csr_sat_cnt: saturating up-counter; clear wins over a same-cycle increment
module feature_csr_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ofs_feature_csr_responder.sv
// ofs_feature_csr_responder: DFH/GUID/scratch MMIO responder; OFS_FEATURE_CSR_ACCESS_CNT_EN adds access counters
module ofs_feature_csr_responder
  import ofs_feature_csr_pkg::*;
#(
  parameter int          ADDR_W       = 12,
  parameter int          TAG_W        = 10,
  parameter logic [63:0] DFH_VALUE    = 64'h0,
  parameter logic [127:0] GUID        = 128'h0,
  parameter int unsigned SCRATCH_ADDR = 'h28,
  parameter logic [63:0] SCRATCH_RST  = 64'h0,
  parameter int unsigned CNT_ADDR     = 'h38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_dw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);
  if (SCRATCH_ADDR % 8 != 0 || SCRATCH_ADDR < 'h18 || CNT_ADDR % 8 != 0 || CNT_ADDR < 'h18 ||
      CNT_ADDR == SCRATCH_ADDR || TAG_W > CSR_TAG_MAX) begin : g_bad_cfg
    $error("ofs_feature_csr_responder: illegal SCRATCH_ADDR/CNT_ADDR/TAG_W configuration");
  end
  localparam logic [ADDR_W-1:0] DFH_A = ADDR_W'(DFH_OFFSET);
  localparam logic [ADDR_W-1:0] GL_A  = ADDR_W'(GUID_L_OFFSET);
  localparam logic [ADDR_W-1:0] GH_A  = ADDR_W'(GUID_H_OFFSET);
  localparam logic [ADDR_W-1:0] SCR_A = ADDR_W'(SCRATCH_ADDR);
  t_csr_state state_q, state_d;
  t_csr_rsp   rsp_q, rsp_d;
  logic [63:0] scratch_q, rd64, cnt_val;
  logic [ADDR_W-4:0] word;
  logic hit_dfh, hit_gl, hit_gh, hit_scr, hit_cnt, rd_acc, wr_acc;
  logic unused;
  assign unused    = ^{req_addr[1:0], rsp_q.tag};
  assign word      = req_addr[ADDR_W-1:3];
  assign hit_dfh   = word == DFH_A[ADDR_W-1:3];
  assign hit_gl    = word == GL_A[ADDR_W-1:3];
  assign hit_gh    = word == GH_A[ADDR_W-1:3];
  assign hit_scr   = word == SCR_A[ADDR_W-1:3];
  assign req_ready = ~rst & (state_q == IDLE | rsp_ready);
  assign rd_acc    = req_valid & req_ready & ~req_write;
  assign wr_acc    = req_valid & req_ready & req_write;
`ifdef OFS_FEATURE_CSR_ACCESS_CNT_EN
  localparam logic [ADDR_W-1:0] CNT_A = ADDR_W'(CNT_ADDR);
  logic [31:0] wr_cnt, rd_cnt;
  logic cnt_clr;
  assign hit_cnt = word == CNT_A[ADDR_W-1:3];
  assign cnt_clr = wr_acc & hit_cnt;
  assign cnt_val = {wr_cnt, rd_cnt};
  feature_csr_sat_cnt #(.WIDTH(32)) u_wr_cnt (.clk, .rst, .inc(wr_acc), .clr(cnt_clr), .cnt(wr_cnt));
  feature_csr_sat_cnt #(.WIDTH(32)) u_rd_cnt (.clk, .rst, .inc(rd_acc), .clr(cnt_clr), .cnt(rd_cnt));
`else
  assign hit_cnt = 1'b0;
  assign cnt_val = '0;
`endif
  assign rd64 = hit_dfh ? DFH_VALUE : hit_gl ? GUID[63:0] : hit_gh ? GUID[127:64] :
                hit_scr ? scratch_q : hit_cnt ? cnt_val : '0;
  always_comb begin
    rsp_d      = '0;
    rsp_d.data = req_dw ? {2{req_addr[2] ? rd64[63:32] : rd64[31:0]}} : rd64;
    rsp_d.tag  = CSR_TAG_MAX'(req_tag);
    rsp_d.err  = ~(hit_dfh | hit_gl | hit_gh | hit_scr | hit_cnt);
    state_d    = rd_acc ? RSP : rsp_ready ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rd_acc) rsp_q <= rsp_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) scratch_q <= SCRATCH_RST;
    else if (wr_acc && hit_scr)
      scratch_q <= !req_dw ? req_wdata : req_addr[2] ? {req_wdata[31:0], scratch_q[31:0]} :
                   {scratch_q[63:32], req_wdata[31:0]};
  assign rsp_valid = state_q == RSP;
  assign rsp_data  = rsp_q.data;
  assign rsp_tag   = rsp_q.tag[TAG_W-1:0];
  assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_ofs_feature_csr_responder.sv
// tb_ofs_feature_csr_responder: directed and random MMIO traffic checked against a register-map model
module tb_ofs_feature_csr_responder;
  localparam int ADDR_W = 12;
  localparam int TAG_W  = 10;
  localparam logic [63:0]  DFH  = 64'h3000_0000_1000_1001;
  localparam logic [127:0] GUID = 128'h56E203E9864F49A7B94B12284C31E02B;
  localparam logic [63:0]  SRST = 64'h0BAD_F00D_5A5A_A5A5;
  localparam int SCR = 'h28;
  localparam int CNT = 'h38;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, req_dw = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0] req_wdata = '0, rsp_data;
  logic [TAG_W-1:0] req_tag = '0, rsp_tag;
  int errs = 0, checks = 0;
  logic [63:0] m_scr = SRST;
  logic [31:0] m_wr = 0, m_rd = 0;
  logic m_v = 0, m_e = 0;
  logic [63:0] m_d = 0;
  logic [TAG_W-1:0] m_t = 0;
  always #5 clk = ~clk;
  ofs_feature_csr_responder #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DFH_VALUE(DFH), .GUID(GUID),
    .SCRATCH_ADDR(SCR), .SCRATCH_RST(SRST), .CNT_ADDR(CNT)) dut (
    .clk, .rst, .req_valid, .req_ready, .req_write, .req_dw, .req_addr, .req_wdata, .req_tag,
    .rsp_valid, .rsp_ready, .rsp_data, .rsp_tag, .rsp_err);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void ref_read(input logic [ADDR_W-1:0] a, input logic dw,
                                   output logic [63:0] d, output logic e);
    logic [63:0] v;
    int off;
    off = int'(a) & ~7;
    e = 0;
    if (off == 'h0) v = DFH;
    else if (off == 'h8) v = GUID[63:0];
    else if (off == 'h10) v = GUID[127:64];
    else if (off == SCR) v = m_scr;
`ifdef OFS_FEATURE_CSR_ACCESS_CNT_EN
    else if (off == CNT) v = {m_wr, m_rd};
`endif
    else begin v = 0; e = 1; end
    d = dw ? (a[2] ? {2{v[63:32]}} : {2{v[31:0]}}) : v;
  endfunction
  task automatic step(input logic v, input logic w, input logic dw, input int a,
                      input logic [63:0] wd, input int t, input logic rr);
    logic acc, e;
    logic [63:0] d;
    int off;
    req_valid = v; req_write = w; req_dw = dw; req_addr = ADDR_W'(a);
    req_wdata = wd; req_tag = TAG_W'(t); rsp_ready = rr;
    @(negedge clk);
    check("req_ready", req_ready, !m_v | rr);
    check("rsp_valid", rsp_valid, m_v);
    if (m_v) begin
      check("rsp_data", rsp_data, m_d);
      check("rsp_tag", rsp_tag, m_t);
      check("rsp_err", rsp_err, m_e);
    end
    acc = v & (!m_v | rr);
    off = a & ~7;
    if (m_v & rr) m_v = 0;
    if (acc & !w) begin
      ref_read(ADDR_W'(a), dw, d, e);
      m_v = 1; m_d = d; m_t = TAG_W'(t); m_e = e;
    end
    if (acc && w && off == SCR)
      m_scr = !dw ? wd : a[2] ? {wd[31:0], m_scr[31:0]} : {m_scr[63:32], wd[31:0]};
`ifdef OFS_FEATURE_CSR_ACCESS_CNT_EN
    if (acc && w && off == CNT) begin m_wr = 0; m_rd = 0; end
    else if (acc) begin
      if (w && m_wr != '1) m_wr++;
      if (!w && m_rd != '1) m_rd++;
    end
`endif
    @(posedge clk); #1;
  endtask
  task automatic rd(input int a, input logic dw, input int t, input logic rr);
    step(1, 0, dw, a, 0, t, rr);
  endtask
  task automatic wr(input int a, input logic dw, input logic [63:0] wd);
    step(1, 1, dw, a, wd, 0, 1);
  endtask
  initial begin
    int addrs[8] = '{'h0, 'h8, 'h10, 'h28, 'h2C, 'h38, 'h3C, 'h100};
    @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_tag", rsp_tag, 0);
    rst = 0;
    @(posedge clk); #1;
    rd('h8, 0, 3, 1); rd('h10, 0, 4, 1); step(0, 0, 0, 0, 0, 0, 1);
    rd('h28, 0, 5, 1);
    wr('h28, 0, 64'hDEADBEEF_CAFEF00D); wr('h2C, 1, 64'hFFFF_0000_1234_5678);
    rd('h28, 0, 6, 1); rd('h2C, 1, 7, 1); rd('h28, 1, 8, 1);
    rd('h8, 0, 9, 1);
    for (int i = 0; i < 5; i++) rd('h10, 0, 10, 0);
    rd('h10, 0, 10, 1); step(0, 0, 0, 0, 0, 0, 1);
    rd('h100, 0, 11, 1); wr('h0, 0, '1); rd('h0, 0, 12, 1); rd('h38, 0, 13, 1);
    rd('h8, 0, 14, 0); step(0, 0, 0, 0, 0, 0, 0);
    rst = 1; #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst req_ready", req_ready, 0);
    check("rst rsp_data", rsp_data, 0);
    m_v = 0; m_scr = SRST; m_wr = 0; m_rd = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 1); rd('h28, 0, 15, 1); step(0, 0, 0, 0, 0, 0, 1);
`ifdef OFS_FEATURE_CSR_ACCESS_CNT_EN
    rst = 1; @(negedge clk); rst = 0; @(posedge clk); #1;
    m_v = 0; m_scr = SRST; m_wr = 0; m_rd = 0;
    wr('h28, 0, 1); wr('h0, 0, 2); wr('h100, 0, 3); rd('h8, 0, 1, 1); rd('h10, 0, 2, 1);
    rd(CNT, 0, 16, 1); step(0, 0, 0, 0, 0, 0, 1);
    check("cnt value", {m_wr, m_rd}, 64'h00000003_00000003);
    wr(CNT, 0, 0); rd(CNT, 0, 17, 1); step(0, 0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << ADDR_W) - 1)) : addrs[$urandom_range(0, 7)];
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
           {$urandom, $urandom}, int'($urandom_range(0, 1023)), $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
